// File: rtl/mult_pkg.sv
// Shared definitions for the shared sequential multiplier: default operand
// width, counter width and the controller state encoding.
package mult_pkg;

    localparam int MULT_N  = 32;
    localparam int MULT_CW = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_core.sv
// Signed radix-2 shift-add multiplier datapath. One step per enabled cycle:
// conditionally add (or, on the sign step, subtract) the multiplicand into the
// upper accumulator, then shift the whole {acc, lo} pair right arithmetically.
// After N steps {acc[N-1:0], lo} holds the exact 2N-bit signed product.
module shift_add_core
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_sub_last,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_product
);

    logic [N-1:0] r_a;
    logic [N:0]   r_acc;
    logic [N-1:0] r_lo;
    logic [N+1:0] w_a_ext;
    logic [N+1:0] w_acc_ext;
    logic [N+1:0] w_sum;

    assign w_a_ext   = {{2{r_a[N-1]}}, r_a};
    assign w_acc_ext = {r_acc[N], r_acc};

    // Partial-product update; two guard bits keep the sum exact before the shift.
    always_comb begin
        w_sum = w_acc_ext;
        if (r_lo[0]) begin
            if (i_sub_last) begin
                w_sum = w_acc_ext - w_a_ext;
            end else begin
                w_sum = w_acc_ext + w_a_ext;
            end
        end
    end

    // Operand load and per-step arithmetic right shift of {acc, lo}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_acc <= '0;
            r_lo  <= '0;
        end else if (i_load) begin
            r_a   <= i_a;
            r_acc <= '0;
            r_lo  <= i_b;
        end else if (i_step) begin
            r_acc <= w_sum[N+1:1];
            r_lo  <= {w_sum[0], r_lo[N-1:1]};
        end
    end

    assign o_product = {r_acc[N-1:0], r_lo};

endmodule

// File: rtl/mult_share_arbiter.sv
// Two requesters share one sequential signed multiplier.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; ready may depend combinationally on valid, valid must not depend on
// ready. Requests are granted only in IDLE, round-robin on contention; the
// result is held in DONE until res_ready, and no request is taken that cycle.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int CW = MULT_CW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid0,
    input  logic [N-1:0]   in_a0,
    input  logic [N-1:0]   in_b0,
    output logic           in_ready0,
    input  logic           in_valid1,
    input  logic [N-1:0]   in_a1,
    input  logic [N-1:0]   in_b1,
    output logic           in_ready1,
    output logic           res_valid,
    output logic [2*N-1:0] res_data,
    output logic           res_id,
    input  logic           res_ready,
    output logic           busy,
    output logic [1:0]     o_dbg_state
);

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic          r_last_id;
    logic          r_res_id;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_accept;
    logic          w_step;
    logic          w_sub_last;
    logic [N-1:0]  w_a;
    logic [N-1:0]  w_b;

    // Round-robin grant in IDLE: on contention the requester not served last wins.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst && (r_state == ST_IDLE)) begin
            w_grant0 = in_valid0 && (!in_valid1 || r_last_id);
            w_grant1 = in_valid1 && (!in_valid0 || !r_last_id);
        end
    end

    assign in_ready0 = w_grant0;
    assign in_ready1 = w_grant1;
    assign w_accept  = w_grant0 || w_grant1;
    assign w_a       = w_grant1 ? in_a1 : in_a0;
    assign w_b       = w_grant1 ? in_b1 : in_b0;

    // Next-state and datapath controls.
    always_comb begin
        w_next_state = r_state;
        w_step       = 1'b0;
        w_sub_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step     = 1'b1;
                w_sub_last = (r_cnt == CNT_LAST);
                if (r_cnt == CNT_LAST) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Step counter and owner bookkeeping; last_id moves only on an accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_last_id <= 1'b1;
            r_res_id  <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_last_id <= w_grant1;
            r_res_id  <= w_grant1;
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    shift_add_core #(
        .N(N)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_sub_last (w_sub_last),
        .i_a        (w_a),
        .i_b        (w_b),
        .o_product  (res_data)
    );

    assign res_valid   = (r_state == ST_DONE);
    assign res_id      = r_res_id;
    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model (grant rule, fixed
// N-cycle latency, hold-until-ready) with an expected-product queue.
module tb_mult_share_arbiter;
    import mult_pkg::*;

    localparam int N = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid0, in_valid1;
    logic [N-1:0]   in_a0, in_b0, in_a1, in_b1;
    logic           in_ready0, in_ready1;
    logic           res_valid;
    logic [2*N-1:0] res_data;
    logic           res_id;
    logic           res_ready;
    logic           busy;
    logic [1:0]     dbg_state;

    mult_share_arbiter #(.N(N), .CW(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid0   (in_valid0),
        .in_a0       (in_a0),
        .in_b0       (in_b0),
        .in_ready0   (in_ready0),
        .in_valid1   (in_valid1),
        .in_a1       (in_a1),
        .in_b1       (in_b1),
        .in_ready1   (in_ready1),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_id      (res_id),
        .res_ready   (res_ready),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- model and scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          m_idle   = 1'b1;
    bit          m_done   = 1'b0;
    int          m_run_left = 0;
    bit          m_last   = 1'b1;
    bit          m_id     = 1'b0;
    logic [63:0] exp_q[$];
    bit          grant_log[$];
    logic        obs_valid;
    logic [63:0] obs_data;
    logic        obs_id;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] ref_product(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    function automatic logic [N-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7fff_ffff;
            4:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle: drive at the falling edge, check 1 time unit later,
    // advance the model on the rising edge.
    task automatic cycle(input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                         input logic v1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                         input logic rr);
        bit   e_r0, e_r1;
        logic [1:0] e_state;
        rst = 1'b1;
        in_valid0 = v0; in_a0 = a0; in_b0 = b0;
        in_valid1 = v1; in_a1 = a1; in_b1 = b1;
        res_ready = rr;
        #1;
        e_r0 = m_idle && v0 && (!v1 || m_last);
        e_r1 = m_idle && v1 && (!v0 || !m_last);
        e_state = m_idle ? ST_IDLE : (m_done ? ST_DONE : ST_RUN);
        check("in_ready0", in_ready0, e_r0);
        check("in_ready1", in_ready1, e_r1);
        check("res_valid", res_valid, m_done);
        check("busy", busy, !m_idle);
        check("dbg_state", dbg_state, e_state);
        if (m_done) begin
            check("res_data", res_data, (exp_q.size() > 0) ? exp_q[0] : 64'hx);
            check("res_id", res_id, m_id);
        end
        obs_valid = res_valid;
        obs_data  = res_data;
        obs_id    = res_id;
        if (in_valid0 && in_ready0) grant_log.push_back(1'b0);
        if (in_valid1 && in_ready1) grant_log.push_back(1'b1);
        @(posedge clk);
        if (m_idle) begin
            if (e_r0 || e_r1) begin
                m_id   = e_r1;
                m_last = e_r1;
                exp_q.push_back(e_r1 ? ref_product(a1, b1) : ref_product(a0, b0));
                m_idle = 1'b0;
                m_run_left = N;
            end
        end else if (!m_done) begin
            m_run_left--;
            if (m_run_left == 0) m_done = 1'b1;
        end else if (rr) begin
            void'(exp_q.pop_front());
            m_done = 1'b0;
            m_idle = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic reset_cycle(input logic v0, input logic v1);
        rst = 1'b0;
        in_valid0 = v0; in_valid1 = v1;
        res_ready = 1'b1;
        #1;
        check("rst_ready0", in_ready0, 1'b0);
        check("rst_ready1", in_ready1, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_res_data", res_data, 64'd0);
        check("rst_res_id", res_id, 1'b0);
        m_idle = 1'b1; m_done = 1'b0; m_run_left = 0; m_last = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n, input logic rr);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, rr);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && !m_idle; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        check("drain_idle", m_idle, 1'b1);
    endtask

    // Single request from one requester; checks latency and the known product.
    task automatic single_op(input bit id, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [63:0] want);
        int n;
        bit seen;
        if (id == 1'b0) cycle(1'b1, a, b, 1'b0, '0, '0, 1'b1);
        else            cycle(1'b0, '0, '0, 1'b1, a, b, 1'b1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
            n++;
            if (obs_valid === 1'b1) seen = 1'b1;
        end
        check("latency", 64'(n - 1), 64'(N));
        check("op_data", obs_data, want);
        check("op_id", obs_id, id);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        in_a0 = '0; in_b0 = '0; in_a1 = '0; in_b1 = '0;
        res_ready = 1'b0;
        @(negedge clk);
        reset_cycle(1'b1, 1'b1);
        reset_cycle(1'b0, 1'b0);

        // basic products, latency and owner id
        single_op(1'b0, 32'd7, -32'sd3, -64'sd21);
        single_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        // contention: grants alternate starting from requester 0
        grant_log.delete();
        for (int i = 0; i < 4 * (N + 2) + 2; i++)
            cycle(1'b1, $urandom, $urandom, 1'b1, $urandom, $urandom, 1'b1);
        drain();
        check("alt_count", 64'(grant_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size()) check("alt_grant", grant_log[i], 64'(i % 2));

        // consumer stall in DONE with a competing request held high
        cycle(1'b1, 32'd123, 32'd456, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < N + 10; i++)
            cycle(1'b0, '0, '0, 1'b1, 32'd9, 32'd9, 1'b0);
        check("stall_done", m_done, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 32'd9, 32'd9, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 32'd9, 32'd9, 1'b1);
        drain();

        // reset in the middle of a run discards it
        cycle(1'b1, 32'd1000, 32'd1000, 1'b0, '0, '0, 1'b1);
        idle_cycles(15, 1'b1);
        reset_cycle(1'b1, 1'b1);
        reset_cycle(1'b1, 1'b1);
        single_op(1'b0, 32'd5, 32'd9, 64'd45);

        // zero and minus-one corners
        single_op(1'b0, 32'd0, 32'hffff_ffff, 64'd0);
        single_op(1'b1, 32'hffff_ffff, 32'hffff_ffff, 64'd1);

        // random traffic
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 1), rand_op(), rand_op(),
                  $urandom_range(0, 1), rand_op(), rand_op(),
                  ($urandom_range(0, 3) != 0));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
